// File: rtl/alu.sv
// EX-stage ALU: combinational arithmetic/logic ops plus a 32-cycle
// shift-add unsigned multiplier that writes the HI/LO register pair.
module alu #(
  parameter logic [5:0] F_add   = 6'd32,
  parameter logic [5:0] F_sub   = 6'd34,
  parameter logic [5:0] F_and   = 6'd36,
  parameter logic [5:0] F_or    = 6'd37,
  parameter logic [5:0] F_slt   = 6'd42,
  parameter logic [5:0] F_multu = 6'd25,
  parameter logic [5:0] F_mfhi  = 6'd16,
  parameter logic [5:0] F_mflo  = 6'd18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [5:0]  ALUOperation,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, MUL} state_t;

  state_t      state, state_next;
  logic [5:0]  count;
  logic [31:0] mcand, mplier, hi, lo;
  logic [63:0] acc, acc_next;
  logic        start, last;

  always_comb begin
    result = '0;
    case (ALUOperation)
      F_add:   result = src1 + src2;
      F_sub:   result = src1 - src2;
      F_and:   result = src1 & src2;
      F_or:    result = src1 | src2;
      F_slt:   result = ($signed(src1) < $signed(src2)) ? 32'd1 : 32'd0;
      F_mfhi:  result = hi;
      F_mflo:  result = lo;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign busy = (state == MUL);

  always_comb begin
    start      = (state == IDLE) && issue && (ALUOperation == F_multu);
    last       = (state == MUL) && (count == 6'd31);
    // Partial product for the current multiplier bit, folded into the running sum.
    acc_next   = acc + (mplier[count[4:0]] ? ({32'd0, mcand} << count) : 64'd0);
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MUL;
      MUL:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= last;
      if (start) begin
        mcand  <= src1;
        mplier <= src2;
        acc    <= '0;
        count  <= '0;
      end else if (state == MUL) begin
        acc   <= acc_next;
        count <= count + 6'd1;
        if (last) {hi, lo} <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: random ALU ops and multiplies against a
// behavioural model using native arithmetic and a 64-bit product.
module tb_alu;

  localparam logic [5:0] F_add   = 6'd32;
  localparam logic [5:0] F_sub   = 6'd34;
  localparam logic [5:0] F_and   = 6'd36;
  localparam logic [5:0] F_or    = 6'd37;
  localparam logic [5:0] F_slt   = 6'd42;
  localparam logic [5:0] F_multu = 6'd25;
  localparam logic [5:0] F_mfhi  = 6'd16;
  localparam logic [5:0] F_mflo  = 6'd18;

  logic        clk = 1'b0;
  logic        rst, issue;
  logic [5:0]  op;
  logic [31:0] src1, src2, result;
  logic        zero, busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  alu #(.F_add(F_add), .F_sub(F_sub), .F_and(F_and), .F_or(F_or), .F_slt(F_slt),
        .F_multu(F_multu), .F_mfhi(F_mfhi), .F_mflo(F_mflo)) dut (
    .clk(clk), .rst(rst), .issue(issue), .ALUOperation(op),
    .src1(src1), .src2(src2), .result(result), .zero(zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [5:0] o, input logic [31:0] a, b);
    int signed sa, sb;
    sa = a; sb = b;
    if (o == F_add)       return a + b;
    else if (o == F_sub)  return a - b;
    else if (o == F_and)  return a & b;
    else if (o == F_or)   return a | b;
    else if (o == F_slt)  return (sa < sb) ? 32'd1 : 32'd0;
    else if (o == F_mfhi) return m_hi;
    else if (o == F_mflo) return m_lo;
    return 32'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; issue = 1'b1; op = F_multu; src1 = 32'd9; src2 = 32'd9;
    step();
    rst = 1'b0; issue = 1'b0; op = F_mfhi;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
    end
    vectors++;
    if (result !== 32'd0) begin
      miscompares++; $display("FAIL reset_hi got %h expected 0", result);
    end
    op = F_mflo; #1;
    vectors++;
    if (result !== 32'd0) begin
      miscompares++; $display("FAIL reset_lo got %h expected 0", result);
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_overrides_issue busy=%b expected 0", busy);
    end
  endtask

  task automatic check_comb(input string name, input logic [5:0] o, input logic [31:0] a, b);
    logic [31:0] exp;
    op = o; src1 = a; src2 = b;
    #1;
    exp = model(o, a, b);
    vectors++;
    if (result !== exp || zero !== (exp == 32'd0)) begin
      miscompares++;
      $display("FAIL %s op=%0d a=%h b=%h got %h/z%b expected %h/z%b",
               name, o, a, b, result, zero, exp, exp == 32'd0);
    end
  endtask

  task automatic test_directed();
    issue = 1'b0;
    check_comb("add_wrap", F_add, 32'hFFFFFFFF, 32'h1);
    check_comb("sub_neg", F_sub, 32'd5, 32'd7);
    check_comb("slt_neg", F_slt, 32'hFFFFFFFF, 32'h1);
    check_comb("slt_pos", F_slt, 32'h1, 32'hFFFFFFFF);
    check_comb("and", F_and, 32'hF0F0, 32'hFF00);
    check_comb("or", F_or, 32'hF0F0, 32'hFF00);
    vectors++;
    op = F_add; src1 = 32'd5; src2 = 32'd7; #1;
    if (result !== 32'd12) begin
      miscompares++; $display("FAIL add_const got %h expected %h", result, 32'd12);
    end
    issue = 1'b1;
    check_comb("undef_63", 6'd63, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    issue = 1'b0;
    check_comb("undef_hi_kept", F_mfhi, 32'd0, 32'd0);
    check_comb("undef_lo_kept", F_mflo, 32'd0, 32'd0);
  endtask

  task automatic test_random_ops();
    logic [5:0]  ops [8];
    logic [5:0]  o;
    logic [31:0] a, b;
    ops = '{F_add, F_sub, F_and, F_or, F_slt, F_mfhi, F_mflo, 6'd0};
    for (int i = 0; i < 60; i++) begin
      o = ops[$urandom_range(0, 7)];
      if (o == 6'd0) begin
        o = 6'($urandom);
        if (o == F_multu) o = 6'd63;
      end
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 4) == 0) b = a;
      if ($urandom_range(0, 4) == 0) a = 32'h80000000;
      issue = 1'($urandom);
      check_comb("rand_op", o, a, b);
      step();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++; $display("FAIL rand_no_mul busy=%b done=%b expected 0 0", busy, done);
      end
    end
    issue = 1'b0;
  endtask

  // Starts at the issue cycle (cycle 0) and returns inside the done cycle.
  task automatic run_mul(input logic [31:0] a, b, input int stray);
    logic [63:0] prod;
    issue = 1'b1; op = F_multu; src1 = a; src2 = b;
    prod = {32'd0, a} * {32'd0, b};
    step();
    for (int c = 1; c <= 32; c++) begin
      issue = 1'b0;
      op = (c % 2 == 1) ? F_mfhi : F_mflo;
      src1 = $urandom; src2 = $urandom;
      if (c == stray) begin
        issue = 1'b1; op = F_multu; src1 = 32'd7; src2 = 32'd7;
      end
      #1;
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_busy cycle %0d busy=%b done=%b expected 1 0", c, busy, done);
      end
      vectors++;
      if (result !== model(op, src1, src2)) begin
        miscompares++;
        $display("FAIL mul_hold_read cycle %0d got %h expected %h", c, result, model(op, src1, src2));
      end
      step();
    end
    issue = 1'b0;
    m_hi = prod[63:32]; m_lo = prod[31:0];
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      miscompares++; $display("FAIL mul_done busy=%b done=%b expected 0 1", busy, done);
    end
    op = F_mfhi; #1;
    vectors++;
    if (result !== m_hi) begin
      miscompares++; $display("FAIL mul_hi %h*%h got %h expected %h", a, b, result, m_hi);
    end
    op = F_mflo; #1;
    vectors++;
    if (result !== m_lo) begin
      miscompares++; $display("FAIL mul_lo %h*%h got %h expected %h", a, b, result, m_lo);
    end
  endtask

  task automatic test_multu();
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    vectors++;
    if (m_hi !== 32'hFFFFFFFE || result !== 32'h00000001) begin
      miscompares++; $display("FAIL max_product lo got %h expected %h", result, 32'h1);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      run_mul($urandom, $urandom, 0);
      step();
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL done_pulse_width done=%b expected 0", done);
    end
  endtask

  task automatic test_back_to_back();
    run_mul(32'd3, 32'd5, 10);
    vectors++;
    if (m_lo !== 32'd15 || result !== 32'd15) begin
      miscompares++; $display("FAIL stray_ignored lo got %h expected %h", result, 32'd15);
    end
    run_mul(32'd7, 32'd7, 0);
    vectors++;
    if (result !== 32'd49) begin
      miscompares++; $display("FAIL b2b_lo got %h expected %h", result, 32'd49);
    end
    run_mul($urandom, $urandom, 20);
    step();
  endtask

  task automatic test_reset_during_mul();
    issue = 1'b1; op = F_multu; src1 = 32'h12345678; src2 = 32'h10;
    step();
    issue = 1'b0; op = F_add;
    for (int c = 1; c < 16; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_mul busy=%b done=%b expected 0 0", busy, done);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL rst_no_done busy=%b done=%b expected 0 0", busy, done);
      end
    end
    check_comb("rst_hi", F_mfhi, 32'd0, 32'd0);
    check_comb("rst_lo", F_mflo, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0; issue = 1'b0; op = F_add; src1 = '0; src2 = '0;
    #2;
    test_reset();
    test_directed();
    test_random_ops();
    test_multu();
    test_back_to_back();
    test_random_ops();
    test_reset_during_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
